// File: rtl/am_pwm_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the AM PWM
// sequencer, its timebase and the modulator that follows it.
package am_pwm_sequencer_pkg;

    localparam int AM_PWM_STEPS         = 8;
    localparam int AM_CLKS_IN_PWM_STEPS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/am_pwm_sequencer_if.sv
// Valid/ready sample stream from the FIFO/DSP into the sequencer.
interface am_pwm_sequencer_if #(
    parameter int SAMPLE_W = 8
) ();

    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/am_pwm_sequencer_pwm_timebase.sv
// Nested clk/step/period counters flagging PWM period and sample
// boundaries; held at zero while clr is high.
module pwm_timebase
    import am_pwm_sequencer_pkg::*;
#(
    parameter int STEPS   = AM_PWM_STEPS,
    parameter int CLKS    = AM_CLKS_IN_PWM_STEPS,
    parameter int PERIODS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic period_end,
    output logic sample_end
);

    localparam int CW = cnt_w(CLKS);
    localparam int SW = cnt_w(STEPS);
    localparam int PW = cnt_w(PERIODS);

    logic [CW-1:0] clk_q, clk_d;
    logic [SW-1:0] step_q, step_d;
    logic [PW-1:0] per_q, per_d;
    logic          last_clk, last_step, last_per;

    assign last_clk   = (clk_q == CW'(CLKS - 1));
    assign last_step  = (step_q == SW'(STEPS - 1));
    assign last_per   = (per_q == PW'(PERIODS - 1));
    assign period_end = last_clk & last_step;
    assign sample_end = period_end & last_per;

    always_comb begin
        clk_d  = last_clk ? '0 : clk_q + CW'(1);
        step_d = step_q;
        per_d  = per_q;
        if (last_clk)
            step_d = last_step ? '0 : step_q + SW'(1);
        if (period_end)
            per_d = last_per ? '0 : per_q + PW'(1);
        if (clr) begin
            clk_d  = '0;
            step_d = '0;
            per_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_q  <= '0;
            step_q <= '0;
            per_q  <= '0;
        end else begin
            clk_q  <= clk_d;
            step_q <= step_d;
            per_q  <= per_d;
        end
    end

endmodule

// File: rtl/am_pwm_sequencer.sv
// Turns a stream of AM samples into glitch-free duty updates aligned
// to PWM period boundaries, with sync strobe and underrun flag.
module am_pwm_sequencer
    import am_pwm_sequencer_pkg::*;
#(
    parameter int PWM_STEPS          = AM_PWM_STEPS,
    parameter int CLKS_IN_PWM_STEPS  = AM_CLKS_IN_PWM_STEPS,
    parameter int PERIODS_PER_SAMPLE = 16,
    parameter int SAMPLE_W           = 8,
    parameter int DUTY_W             = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    am_pwm_sequencer_if.slave   s,
    output logic [DUTY_W-1:0]   duty,
    output logic                duty_load,
    output logic                period_start,
    output logic                underrun,
    input  logic                underrun_clr,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                load_q, load_d;
    logic                ps_q, ps_d;
    logic                ur_q, ur_d;
    logic [SAMPLE_W-1:0] nxt_q, nxt_d;
    logic                full_q, full_d;
    logic                period_end, sample_end;
    logic                ready, accept;

    function automatic logic [DUTY_W-1:0] clamp(input logic [SAMPLE_W-1:0] x);
        if (int'(x) > PWM_STEPS)
            return DUTY_W'(PWM_STEPS);
        return DUTY_W'(x);
    endfunction

    pwm_timebase #(
        .STEPS   (PWM_STEPS),
        .CLKS    (CLKS_IN_PWM_STEPS),
        .PERIODS (PERIODS_PER_SAMPLE)
    ) u_tb (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q != RUN),
        .period_end (period_end),
        .sample_end (sample_end)
    );

    assign ready        = (state_q != IDLE) & ~full_q;
    assign accept       = s.s_valid & ready;
    assign s.s_ready    = ready;
    assign duty         = duty_q;
    assign duty_load    = load_q;
    assign period_start = ps_q;
    assign underrun     = ur_q;
    assign busy         = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        load_d  = 1'b0;
        ps_d    = 1'b0;
        ur_d    = underrun_clr ? 1'b0 : ur_q;
        nxt_d   = nxt_q;
        full_d  = full_q;
        if (accept) begin
            nxt_d  = s.s_data;
            full_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                duty_d = '0;
                if (enable)
                    state_d = PRIME;
            end
            PRIME: begin
                if (full_q) begin
                    full_d = 1'b0;
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                        duty_d  = clamp(nxt_q);
                        load_d  = 1'b1;
                        ps_d    = 1'b1;
                    end
                end
            end
            RUN: begin
                ps_d = period_end;
                if (sample_end) begin
                    // Stopping drops the carrier: no sync strobe, and a
                    // sample landing on this edge is discarded too.
                    if (!enable) begin
                        state_d = IDLE;
                        duty_d  = '0;
                        load_d  = 1'b1;
                        ps_d    = 1'b0;
                        full_d  = 1'b0;
                    end else if (full_q) begin
                        duty_d = clamp(nxt_q);
                        load_d = 1'b1;
                        full_d = 1'b0;
                    end else begin
                        ur_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            load_q  <= 1'b0;
            ps_q    <= 1'b0;
            ur_q    <= 1'b0;
            nxt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            load_q  <= load_d;
            ps_q    <= ps_d;
            ur_q    <= ur_d;
            nxt_q   <= nxt_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: tb/tb_am_pwm_sequencer.sv
// Directed plus random stimulus against a time-indexed behavioural
// model of the sequencer (8 steps x 2 clks x 3 periods = 48 clocks).
module tb_am_pwm_sequencer;

    localparam int STEPS  = 8;
    localparam int PERIOD = 16;
    localparam int SAMPLE = 48;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       underrun_clr;
    logic [7:0] duty;
    logic       duty_load, period_start, underrun, busy;

    am_pwm_sequencer_if #(.SAMPLE_W(8)) ifc ();

    am_pwm_sequencer #(
        .PWM_STEPS          (8),
        .CLKS_IN_PWM_STEPS  (2),
        .PERIODS_PER_SAMPLE (3),
        .SAMPLE_W           (8),
        .DUTY_W             (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s            (ifc.slave),
        .duty         (duty),
        .duty_load    (duty_load),
        .period_start (period_start),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: mode 0 stopped, 1 waiting for first sample, 2 carrier on.
    // m_t is the clock index within the carrier run; boundaries fall
    // at multiples of the period and sample lengths.
    int         m_mode, m_t;
    bit         m_full, m_load, m_ps, m_ur;
    logic [7:0] m_data, m_duty;

    function automatic logic [7:0] clampm(input logic [7:0] x);
        return (x > STEPS) ? 8'(STEPS) : x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_t = 0; m_full = 0; m_data = 0;
            m_duty = 0; m_load = 0; m_ps = 0; m_ur = 0;
        end else begin
            cyc++;
            begin
                bit         acc, full_old;
                logic [7:0] data_old;
                acc      = ifc.s_valid && m_mode != 0 && !m_full;
                full_old = m_full;
                data_old = m_data;
                m_load   = 0;
                m_ps     = 0;
                if (underrun_clr) m_ur = 0;
                if (acc) begin m_full = 1; m_data = ifc.s_data; end
                if (m_mode == 0) begin
                    if (enable) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (full_old) begin
                        m_full = 0;
                        if (!enable) m_mode = 0;
                        else begin
                            m_mode = 2; m_t = 0;
                            m_duty = clampm(data_old);
                            m_load = 1; m_ps = 1;
                        end
                    end
                end else begin
                    m_t++;
                    m_ps = (m_t % PERIOD) == 0;
                    if ((m_t % SAMPLE) == 0) begin
                        if (!enable) begin
                            m_mode = 0; m_duty = 0; m_load = 1;
                            m_ps = 0; m_full = 0;
                        end else if (full_old) begin
                            m_duty = clampm(data_old);
                            m_load = 1; m_full = 0;
                        end else begin
                            m_ur = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("duty", 32'(duty), 32'(m_duty));
            chk("duty_load", 32'(duty_load), 32'(m_load));
            chk("period_start", 32'(period_start), 32'(m_ps));
            chk("underrun", 32'(underrun), 32'(m_ur));
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("s_ready", 32'(ifc.s_ready),
                32'(m_mode != 0 && !m_full));
        end
    end

    task automatic push(input logic [7:0] v);
        int n = 0;
        ifc.s_data  = v;
        ifc.s_valid = 1'b1;
        while (!ifc.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'(n), 32'(0));
        @(negedge clk);
        ifc.s_valid = 1'b0;
    endtask

    task automatic wait_load(output int t);
        bit found = 0;
        t = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (duty_load) begin found = 1; t = cyc; end
        end
        if (!found) chk("load_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, t4;
        rst = 1; enable = 0; underrun_clr = 0;
        ifc.s_valid = 0; ifc.s_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_duty", 32'(duty), 0);
        chk("rst_load", 32'(duty_load), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_ur", 32'(underrun), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ifc.s_ready), 0);
        rst = 0;
        @(negedge clk);
        chk_en = 1;

        enable = 1;
        push(8'd5);
        wait_load(t0);
        chk("start_duty", 32'(duty), 5);
        chk("start_ps", 32'(period_start), 1);
        chk("start_busy", 32'(busy), 1);
        repeat (PERIOD) @(negedge clk);
        chk("ps_16", 32'(period_start), 1);

        push(8'd3);
        chk("full_not_ready", 32'(ifc.s_ready), 0);
        wait_load(t1);
        chk("load_gap", 32'(t1 - t0), 48);
        chk("stream_duty", 32'(duty), 3);

        repeat (SAMPLE) @(negedge clk);
        chk("ur_set", 32'(underrun), 1);
        chk("ur_duty_hold", 32'(duty), 3);
        chk("ur_no_load", 32'(duty_load), 0);
        underrun_clr = 1;
        @(negedge clk);
        underrun_clr = 0;
        chk("ur_clr", 32'(underrun), 0);
        push(8'd6);
        wait_load(t2);
        chk("ur_gap", 32'(t2 - t1), 96);
        chk("ur_duty", 32'(duty), 6);

        push(8'd200);
        wait_load(t3);
        chk("clamp_duty", 32'(duty), 8);

        repeat (10) @(negedge clk);
        enable = 0;
        push(8'd7);
        wait_load(t4);
        chk("stop_gap", 32'(t4 - t3), 48);
        chk("stop_duty", 32'(duty), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_ready", 32'(ifc.s_ready), 0);
        enable = 1;
        @(negedge clk);
        chk("discarded", 32'(ifc.s_ready), 1);

        push(8'd4);
        wait_load(t0);
        repeat (20) @(negedge clk);
        chk_en = 0;
        enable = 0;
        #2 rst = 1;
        #1;
        chk("arst_duty", 32'(duty), 0);
        chk("arst_load", 32'(duty_load), 0);
        chk("arst_ps", 32'(period_start), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(ifc.s_ready), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_en = 1;

        enable = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            ifc.s_valid  = ($urandom_range(0, 3) == 0);
            ifc.s_data   = ($urandom_range(0, 7) == 0) ?
                           8'($urandom) : 8'($urandom_range(0, 12));
            underrun_clr = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        ifc.s_valid = 0;
        underrun_clr = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/am_pwm_sequencer.md
Name: am_pwm_sequencer

Overview:
Sequences the AM PWM modulator: accepts AM amplitude samples over a valid/ready stream and presents them to the modulator as duty values. Each duty value is held for an integer number of PWM periods and changes only on period boundaries, so output pulses are never glitched. Generates the period sync strobe that restarts the modulator counter. Flags underruns and performs orderly start/stop of the carrier. Sits between the sample source (FIFO/DSP) and the modulator in the TX chain.

Parameters:
PWM_STEPS, `AM_PWM_STEPS, steps per PWM period (>=2)
CLKS_IN_PWM_STEPS, `AM_CLKS_IN_PWM_STEPS, clk cycles per PWM step (>=1)
PERIODS_PER_SAMPLE, 16, PWM periods each sample is held (>=1)
SAMPLE_W, 8, input sample width, unsigned
DUTY_W, 8, duty output width; must satisfy 2^DUTY_W > PWM_STEPS

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  level; 1 = run carrier, 0 = stop at next sample boundary
s_data  in  SAMPLE_W  amplitude sample
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid & s_ready
duty  out  DUTY_W  duty value to modulator, 0..PWM_STEPS
duty_load  out  1  1-cycle pulse in the first cycle a new duty value is driven
period_start  out  1  1-cycle pulse in the first cycle of every PWM period (modulator sync)
underrun  out  1  sticky: a sample boundary was reached with no sample buffered
underrun_clr  in  1  clears underrun
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE, duty=0, duty_load=0, period_start=0, underrun=0, counters=0, next buffer empty. Any pending sample is discarded.
- All outputs are registered except s_ready, which is s_ready = (state != IDLE) & !next_full.
- One-entry buffer next_data/next_full. An accept sets it; a consume clears it. Accept and consume cannot coincide, because s_ready is low while the buffer is full.
- Counters: clk_cnt 0..CLKS_IN_PWM_STEPS-1, step_cnt 0..PWM_STEPS-1, per_cnt 0..PERIODS_PER_SAMPLE-1. Nested wrap; they run only in RUN.
- period_end = last clk_cnt & last step_cnt. sample_end = period_end & last per_cnt.
- clamp(x) = min(x, PWM_STEPS).
- States:
  IDLE: duty=0. If enable=1, go to PRIME.
  PRIME: wait for next_full. At the edge where next_full=1:
    - if enable=0, go to IDLE, discarding the buffer;
    - otherwise go to RUN: duty<=clamp(next_data), duty_load<=1, period_start<=1, counters<=0, buffer cleared.
  RUN: counters advance every clock. At each period_end, period_start<=1 for the next cycle. At sample_end:
    - enable=0: go to IDLE, duty<=0, duty_load<=1; any buffered sample is discarded.
    - else if next_full: duty<=clamp(next_data), duty_load<=1, buffer cleared.
    - else: underrun<=1, duty held, no duty_load; the next sample slot starts anyway (counters wrap).
- Timing: sample period = PWM_STEPS*CLKS_IN_PWM_STEPS*PERIODS_PER_SAMPLE clocks. The first duty_load occurs 1 cycle after the accept in PRIME.
- enable deasserted mid-sample: the current sample completes (no truncation).
- underrun_clr coinciding with an underrun set: the set wins.
- The PRIME state does not time out. The upstream source is responsible for supplying the first sample.

Decomposition:
- project_defines: AM_PWM_STEPS, AM_CLKS_IN_PWM_STEPS, and the state encodings (IDLE=0, PRIME=1, RUN=2), shared with the modulator and benches.
- Sub-module pwm_timebase holds the three nested counters and emits period_end and sample_end, with a clear input. The modulator can reuse it.

Test Plan:
Bench parameters: PWM_STEPS=8, CLKS_IN_PWM_STEPS=2, PERIODS_PER_SAMPLE=3 (48-clock sample).
- Reset: assert rst for 2 cycles -> duty=0, duty_load=0, period_start=0, underrun=0, busy=0, s_ready=0. Assert rst asynchronously mid-RUN -> all outputs 0 before the next edge.
- Start: enable=1, push 5 -> busy=1. One cycle after the accept, duty=5 with duty_load and period_start both high. period_start then repeats every 16 clocks.
- Steady stream: push 3 during the first sample -> s_ready low until the duty=3 load at clock 48. duty_load is exactly 48 clocks apart and there are no underruns.
- Underrun: do not push a second sample -> at clock 48 underrun=1, duty stays 5, no duty_load. Then push 6 and pulse underrun_clr -> underrun=0 and duty=6 at clock 96.
- Clamp: push 200 -> duty=8.
- Stop: drop enable at clock 10 of a sample -> duty holds until clock 48, then duty=0 with a duty_load pulse, busy=0, s_ready=0. A sample buffered at that point is discarded.
